fp_div_seq: RTL and testbench



---
 rtl/fp_div_seq_if.sv | 26 ++
 rtl/fp_div_seq.sv | 155 +++++++++++++++
 tb/tb_fp_div_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fp_div_seq_if.sv
// Handshake bundle for the sequential fixed-point divider: operand
// channel (in_valid/in_ready/a/b) and result channel
// (out_valid/out_ready/out/flags).
interface fp_div_seq_if #(
    parameter int fp_width = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic signed [fp_width-1:0] a;
    logic signed [fp_width-1:0] b;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [fp_width-1:0] out;
    logic                       overflow;
    logic                       div_by_zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, overflow, div_by_zero
    );
endinterface

// File: rtl/fp_div_seq.sv
// Sequential signed fixed-point divider (a / b, same Q format).
// Radix-2 restoring division on magnitudes, one quotient bit per cycle,
// followed by one sign-fix/saturation cycle. Divide-by-zero also passes
// through the fix cycle so its result appears one cycle after accept.
module fp_div_seq #(
    parameter int fp_width = 16,
    parameter int fp_frac  = 8
) (
    input logic         clk,
    input logic         rst_n,
    fp_div_seq_if.slave bus
);
    localparam int N  = fp_width + fp_frac;
    localparam int CW = $clog2(N);

    localparam logic [fp_width-1:0] MAX_VAL = {1'b0, {(fp_width-1){1'b1}}};
    localparam logic [fp_width-1:0] MIN_VAL = {1'b1, {(fp_width-1){1'b0}}};
    localparam logic [N-1:0] MAX_POS_Q = {{(N-fp_width+1){1'b0}}, {(fp_width-1){1'b1}}};
    localparam logic [N-1:0] MAX_NEG_Q = {{(N-fp_width){1'b0}}, 1'b1, {(fp_width-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

    state_t               state_q, state_d;
    logic                 sign_q, sign_d;
    logic                 sign_a_q, sign_a_d;
    logic                 zero_q, zero_d;
    logic [fp_width-1:0]  mag_b_q, mag_b_d;
    logic [N-1:0]         dvd_q, dvd_d;
    logic [fp_width:0]    rem_q, rem_d;
    logic [N-1:0]         quo_q, quo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [fp_width-1:0]  res_q, res_d;
    logic                 ovf_q, ovf_d;
    logic                 dbz_q, dbz_d;

    logic [fp_width+1:0]  rem_shift;
    logic [fp_width:0]    sat;

    // Two's complement magnitude; the most negative value maps to 2^(fp_width-1).
    function automatic logic [fp_width-1:0] magnitude(input logic [fp_width-1:0] v);
        return v[fp_width-1] ? (~v + 1'b1) : v;
    endfunction

    // Apply sign to the truncated quotient magnitude and clamp to range.
    // Returns {overflow, value}.
    function automatic logic [fp_width:0] saturate(input logic neg, input logic [N-1:0] q);
        logic [fp_width-1:0] lo;
        lo = q[fp_width-1:0];
        if (!neg) begin
            if (q > MAX_POS_Q) return {1'b1, MAX_VAL};
            return {1'b0, lo};
        end
        if (q > MAX_NEG_Q) return {1'b1, MIN_VAL};
        return {1'b0, ~lo + 1'b1};
    endfunction

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.out         = res_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;

    // Next-state logic: operand capture, one restoring step per DIV cycle, sign fix.
    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        sign_a_d  = sign_a_q;
        zero_d    = zero_q;
        mag_b_d   = mag_b_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;
        rem_shift = {rem_q, dvd_q[N-1]};
        sat       = saturate(sign_q, quo_q);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d   = bus.a[fp_width-1] ^ bus.b[fp_width-1];
                    sign_a_d = bus.a[fp_width-1];
                    mag_b_d  = magnitude(bus.b);
                    dvd_d    = {magnitude(bus.a), {fp_frac{1'b0}}};
                    rem_d    = '0;
                    quo_d    = '0;
                    cnt_d    = CW'(N - 1);
                    zero_d   = (bus.b == '0);
                    state_d  = (bus.b == '0) ? FIX : DIV;
                end
            end
            DIV: begin
                dvd_d = dvd_q << 1;
                if (rem_shift >= {1'b0, 1'b0, mag_b_q}) begin
                    rem_d = rem_shift[fp_width:0] - {1'b0, mag_b_q};
                    quo_d = {quo_q[N-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[fp_width:0];
                    quo_d = {quo_q[N-2:0], 1'b0};
                end
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FIX: begin
                if (zero_q) begin
                    res_d = sign_a_q ? MIN_VAL : MAX_VAL;
                    ovf_d = 1'b0;
                    dbz_d = 1'b1;
                end else begin
                    res_d = sat[fp_width-1:0];
                    ovf_d = sat[fp_width];
                    dbz_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; asynchronous reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            sign_a_q <= 1'b0;
            zero_q   <= 1'b0;
            mag_b_q  <= '0;
            dvd_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            sign_a_q <= sign_a_d;
            zero_q   <= zero_d;
            mag_b_q  <= mag_b_d;
            dvd_q    <= dvd_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
        end
    end
endmodule

// File: tb/tb_fp_div_seq.sv
// Testbench for fp_div_seq: directed cases plus randomized operands
// checked against an integer-arithmetic reference model.
module tb_fp_div_seq;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    fp_div_seq_if #(.fp_width(16)) bus ();

    fp_div_seq #(.fp_width(16), .fp_frac(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: quotient = trunc(a * 2^8 / b), clamped to signed 16-bit.
    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] eo, output logic eov, output logic edz);
        longint sa, sb, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            edz = 1'b1;
            eov = 1'b0;
            eo  = (sa < 0) ? 16'h8000 : 16'h7FFF;
        end else begin
            edz = 1'b0;
            q   = (sa * 256) / sb;
            if (q > 32767) begin
                eo = 16'h7FFF; eov = 1'b1;
            end else if (q < -32768) begin
                eo = 16'h8000; eov = 1'b1;
            end else begin
                eo = q[15:0]; eov = 1'b0;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eo, input logic eov, input logic edz, input int elat);
        int n;
        int lat;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".in_ready"}, bus.in_ready, 1);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, lat, elat);
        chk({tag, ".out"}, $unsigned(bus.out), eo);
        chk({tag, ".overflow"}, bus.overflow, eov);
        chk({tag, ".div_by_zero"}, bus.div_by_zero, edz);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, ".out_valid_drop"}, bus.out_valid, 0);
        chk({tag, ".in_ready_back"}, bus.in_ready, 1);
    endtask

    initial begin
        logic [15:0] ra, rb, eo;
        logic        eov, edz;
        int          n;
        int          r;
        logic        seen;

        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst.in_ready", bus.in_ready, 1);
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.out", $unsigned(bus.out), 0);
        chk("rst.overflow", bus.overflow, 0);
        chk("rst.div_by_zero", bus.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic, signs/truncation
        run_op("basic", 16'h0180, 16'h0080, 16'h0300, 1'b0, 1'b0, 25);
        run_op("third", 16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 25);
        run_op("neg_third", 16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0, 25);
        run_op("neg_quarter", 16'hFF00, 16'h0400, 16'hFFC0, 1'b0, 1'b0, 25);
        run_op("neg_neg", 16'hFF00, 16'hFF00, 16'h0100, 1'b0, 1'b0, 25);

        // Saturation boundaries
        run_op("sat_pos", 16'h6400, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 25);
        run_op("min_exact", 16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, 25);
        run_op("min_neg1", 16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0, 25);

        // Divide by zero
        run_op("dbz_neg", 16'hFE00, 16'h0000, 16'h8000, 1'b0, 1'b1, 1);
        run_op("dbz_zero", 16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 1);

        // Backpressure: result held, busy input ignored
        @(negedge clk);
        bus.a = 16'h0180; bus.b = 16'h0080; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bp.out_valid", bus.out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            @(negedge clk);
            chk("bp.hold_out", $unsigned(bus.out), 16'h0300);
            chk("bp.hold_valid", bus.out_valid, 1);
            chk("bp.hold_ready", bus.in_ready, 0);
            chk("bp.hold_flags", {bus.overflow, bus.div_by_zero}, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp.release_valid", bus.out_valid, 0);
        chk("bp.release_ready", bus.in_ready, 1);
        chk("bp.release_out", $unsigned(bus.out), 16'h0300);

        // Reset in the middle of DIV
        run_op("pre_rst", 16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 25);
        @(negedge clk);
        bus.a = 16'h0180; bus.b = 16'h0080; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.out", $unsigned(bus.out), 0);
        chk("midrst.out_valid", bus.out_valid, 0);
        chk("midrst.flags", {bus.overflow, bus.div_by_zero}, 0);
        chk("midrst.in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | bus.out_valid;
        end
        chk("midrst.no_result", seen, 0);
        run_op("post_rst", 16'h0200, 16'h0100, 16'h0200, 1'b0, 1'b0, 25);

        // Randomized operands against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            r  = int'($urandom_range(0, 9));
            if (r == 0)      rb = 16'h0000;
            else if (r < 4)  rb = 16'($urandom_range(1, 16'h03FF));
            else if (r == 4) rb = 16'hFFFF;
            else             rb = 16'($urandom);
            if (r == 9) ra = 16'h8000;
            model(ra, rb, eo, eov, edz);
            run_op("rand", ra, rb, eo, eov, edz, (rb == 16'h0000) ? 1 : 25);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
